uart_tx_mmio: RTL
=================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter BASE, default 32'hFF20_0100, word-aligned base address of the 3-register window.
REQ-002 Parameter DEPTH, default 8, TX FIFO entries; power of two, 2..16.
REQ-003 Parameter DEFAULT_DIV, default 16'd434, clocks per bit after reset (50 MHz / 115200).
REQ-004 iCLK  input  1  single clock; all state updates on its rising edge.
REQ-005 iRST  input  1  reset; synchronous and active-low.
REQ-006 DwReadEnable  input  1  CPU data-bus read strobe.
REQ-007 DwWriteEnable  input  1  CPU data-bus write strobe.
REQ-008 DwByteEnable  input  4  write byte lanes.
REQ-009 DwAddress  input  32  byte address.
REQ-010 DwWriteData  input  32  write data.
REQ-011 oReadData  output  32  read data, combinational; 0 when not selected.
REQ-012 oHit  output  1  high when DwAddress lies in BASE..BASE+8 (word-aligned); combinational.
REQ-013 oTX  output  1  serial line; idle high.
REQ-014 oIRQ  output  1  high while FIFO empty and FSM in IDLE; registered.

Function
REQ-015 Register map: +0 DATA (write-only, read returns 0); +4 STATUS (bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits[8:4] count, others 0); +8 DIV (bits[15:0] read/write, others 0).
REQ-016 Write to DATA with DwWriteEnable=1 and DwByteEnable[0]=1 pushes DwWriteData[7:0] in the same edge; other lane bits are ignored.
REQ-017 Push while full: byte dropped, FIFO unchanged, overflow set (sticky).
REQ-018 Write to STATUS with DwWriteData[3]=1 and DwByteEnable[0]=1 clears overflow; all other STATUS bits are read-only.
REQ-019 Write to DIV updates bits whose byte lane is enabled; the new value applies at the next START entry, never mid-frame.
REQ-020 Effective divisor of 0 is treated as 1.
REQ-021 FSM states: IDLE, START, DATA, STOP.
REQ-022 IDLE -> START on the edge after FIFO becomes non-empty; that edge pops the head byte into a shift register and latches the divisor.
REQ-023 START drives oTX=0 for DIV clocks, then -> DATA.
REQ-024 DATA sends 8 bits LSB first, DIV clocks each, then -> STOP.
REQ-025 STOP drives oTX=1 for DIV clocks, then -> START if FIFO non-empty (pop in the same edge), else -> IDLE. Back-to-back frames have no idle gap.
REQ-026 One frame = exactly 10*DIV clocks.
REQ-027 A simultaneous push and pop leaves count unchanged and is accepted when full (pop frees the slot the same edge).
REQ-028 FIFO pointers wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-029 busy = FSM not IDLE.
REQ-030 Reads have no side effects; DwReadEnable only gates oReadData (0 when low).

Reset
REQ-031 On iRST=0 at a rising edge: FSM=IDLE, FIFO empty, count=0, overflow=0, DIV=DEFAULT_DIV, oTX=1, oIRQ=1.
REQ-032 Reset asserted mid-frame aborts the frame: oTX=1 on the next edge, queued bytes discarded.
REQ-033 Bus writes in a reset cycle are ignored.

Verification
REQ-034 Reset, then read STATUS -> 0x0000_0002; read DIV -> 434; oTX=1; oIRQ=1.
REQ-035 DIV=4, write 0x55 to DATA -> oTX low 4 clocks, then 1,0,1,0,1,0,1,0 for 4 clocks each, then high 4 clocks; 40 clocks total; oIRQ returns to 1.
REQ-036 DIV=2, 9 back-to-back DATA writes while DEPTH=8 -> first byte pops the edge after its write, the remaining 8 fill the FIFO, STATUS full=1 and count=8; a 10th write sets overflow; writing STATUS 0x8 clears it.
REQ-037 Write 0xA5 with DwByteEnable=4'b0010 -> no push; count stays 0.
REQ-038 Write DIV=8 during a DIV=2 frame -> current frame keeps 2-clock bits; the next frame uses 8-clock bits.
REQ-039 iRST=0 during DATA state with 3 bytes queued -> next edge: oTX=1, STATUS=0x2, DIV=434.

Source files
------------

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the UART transmitter register window.
interface uart_tx_mmio_if;
  logic        DwReadEnable;
  logic        DwWriteEnable;
  logic [3:0]  DwByteEnable;
  logic [31:0] DwAddress;
  logic [31:0] DwWriteData;
  logic [31:0] oReadData;
  logic        oHit;

  modport master (
    output DwReadEnable,
    output DwWriteEnable,
    output DwByteEnable,
    output DwAddress,
    output DwWriteData,
    input  oReadData,
    input  oHit
  );

  modport slave (
    input  DwReadEnable,
    input  DwWriteEnable,
    input  DwByteEnable,
    input  DwAddress,
    input  DwWriteData,
    output oReadData,
    output oHit
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable bit divisor.
// Window: +0 DATA (push), +4 STATUS, +8 DIV.
module uart_tx_mmio #(
  parameter logic [31:0] BASE        = 32'hFF20_0100,
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic          iCLK,
  input  logic          iRST,
  uart_tx_mmio_if.slave bus,
  output logic          oTX,
  output logic          oIRQ
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Address decode
  logic [31:0] offset;
  logic        sel_data, sel_stat, sel_div;

  assign offset   = bus.DwAddress - BASE;
  assign sel_data = (offset == 32'd0);
  assign sel_stat = (offset == 32'd4);
  assign sel_div  = (offset == 32'd8);
  assign bus.oHit = sel_data | sel_stat | sel_div;

  // Writes landing in a reset cycle must have no effect.
  logic bus_we;
  logic push_req, ovf_clr;

  assign bus_we   = bus.DwWriteEnable & iRST;
  assign push_req = bus_we & sel_data & bus.DwByteEnable[0];
  assign ovf_clr  = bus_we & sel_stat & bus.DwByteEnable[0] & bus.DwWriteData[3];

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            full, empty, pop, push;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // A pop in the same edge frees a slot, so a push into a full FIFO is still taken.
  assign push  = push_req & (~full | pop);

  // Control/status registers
  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;
  logic [15:0] div_eff;

  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;

  // Transmit FSM state
  state_e      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [15:0] tick_q, tick_d;
  logic [15:0] div_lat_q, div_lat_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;
  logic        bit_done;
  logic        busy;

  assign bit_done = (tick_q == div_lat_q - 16'd1);
  assign busy     = (state_q != StIdle);

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Overflow flag and divisor next-state
  always_comb begin
    ovf_d = ovf_q;
    div_d = div_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
    end
    if (bus_we && sel_div && bus.DwByteEnable[0]) begin
      div_d[7:0] = bus.DwWriteData[7:0];
    end
    if (bus_we && sel_div && bus.DwByteEnable[1]) begin
      div_d[15:8] = bus.DwWriteData[15:8];
    end
  end

  // FSM next-state; a frame start pops the head byte and latches the divisor
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tick_d    = tick_q;
    div_lat_d = div_lat_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          state_d   = StStart;
          shift_d   = mem_q[rd_ptr_q];
          div_lat_d = div_eff;
          tick_d    = 16'd0;
        end
      end
      StStart: begin
        if (bit_done) begin
          tick_d    = 16'd0;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      StData: begin
        if (bit_done) begin
          tick_d  = 16'd0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      StStop: begin
        if (bit_done) begin
          tick_d = 16'd0;
          if (!empty) begin
            pop       = 1'b1;
            state_d   = StStart;
            shift_d   = mem_q[rd_ptr_q];
            div_lat_d = div_eff;
          end else begin
            state_d = StIdle;
          end
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line and interrupt are registered from next-state so they change with the state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    irq_d = (state_d == StIdle) && (count_d == '0);
  end

  // FSM, line and interrupt registers
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q   <= StIdle;
      shift_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      tick_q    <= 16'd0;
      div_lat_q <= 16'd1;
      tx_q      <= 1'b1;
      irq_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tick_q    <= tick_d;
      div_lat_q <= div_lat_d;
      tx_q      <= tx_d;
      irq_q     <= irq_d;
    end
  end

  // FIFO pointers, count and control registers
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty
  always_ff @(posedge iCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.DwWriteData[7:0];
    end
  end

  // Read mux; reads never change state
  logic [31:0] status;

  assign status = {23'd0, 5'(count_q), ovf_q, busy, empty, full};

  always_comb begin
    bus.oReadData = 32'd0;
    if (bus.DwReadEnable) begin
      if (sel_stat) begin
        bus.oReadData = status;
      end else if (sel_div) begin
        bus.oReadData = {16'd0, div_q};
      end
    end
  end

  assign oTX  = tx_q;
  assign oIRQ = irq_q;

  logic unused_bus;
  assign unused_bus = ^{bus.DwWriteData[31:16], bus.DwByteEnable[3:2]};

endmodule
